// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 receive path.
//   ps2_state_e   : receiver frame FSM states
//   PS2_PREFIX_*  : scan-code prefix bytes folded into entry flags
//   ENTRY_*       : bit positions inside a 10-bit FIFO entry {rel, ext, code}
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_e;

  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_REL = 8'hF0;

  localparam int ENTRY_CODE_LSB = 0;
  localparam int ENTRY_CODE_MSB = 7;
  localparam int ENTRY_EXT      = 8;
  localparam int ENTRY_REL      = 9;
  localparam int ENTRY_W        = 10;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO.
//   push/push_data : write request (accepted when not full, or when full
//                    and a real pop happens in the same cycle)
//   pop            : pop request (ignored when empty)
//   rd_data        : head entry, combinational from storage
//   count          : entries held; full/empty derived from it
module sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = (AW+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr, rptr;
  logic             pop_ok, push_ok;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign count   = wptr - rptr;
  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign rd_data = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[wptr[AW-1:0]] <= push_data;
        wptr <= wptr + ONE;
      end
      if (pop_ok) rptr <= rptr + ONE;
    end
  end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 host receiver with prefix folding and an entry FIFO.
//   ps2_clk/ps2_data : asynchronous device pins, synchronised here
//   rd_en/rd_data/rd_valid/count : show-ahead FIFO read side
//   overflow/parity_err/frame_err : sticky error flags, cleared by err_clr
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 20000,
  parameter int DECODE_PREFIX  = 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            ps2_clk,
  input  logic                            ps2_data,
  input  logic                            rd_en,
  output logic [9:0]                      rd_data,
  output logic                            rd_valid,
  output logic [$clog2(FIFO_DEPTH):0]     count,
  output logic                            overflow,
  output logic                            parity_err,
  output logic                            frame_err,
  input  logic                            err_clr
);
  localparam int  TW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam bit  DEC = (DECODE_PREFIX != 0);

  logic [SYNC_STAGES-1:0] clk_sync, dat_sync;
  logic                   clk_prev, fall, din;

  ps2_state_e state;
  logic [2:0] bitcnt;
  logic [7:0] shreg;
  logic       par_bit;
  logic [TW-1:0] tmo_cnt;
  logic       ext_f, rel_f;

  logic       stop_edge, par_ok, stop_ok, accept, is_ext, is_rel, tmo_hit;
  logic       push, full, empty, ovf_set;
  logic [ENTRY_W-1:0] push_data;

  // Synchronisers idle high so reset release never fakes a falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync <= '1;
      dat_sync <= '1;
      clk_prev <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_data};
      clk_prev <= clk_sync[SYNC_STAGES-1];
    end
  end

  assign fall = clk_prev & ~clk_sync[SYNC_STAGES-1];
  assign din  = dat_sync[SYNC_STAGES-1];

  // Frame checks resolve on the stop-bit sample so the push lands this edge.
  assign stop_edge = (state == STOP) && fall;
  assign par_ok    = ^{shreg, par_bit};
  assign stop_ok   = din;
  assign accept    = stop_edge && par_ok && stop_ok;
  assign is_ext    = DEC && (shreg == PS2_PREFIX_EXT);
  assign is_rel    = DEC && (shreg == PS2_PREFIX_REL);
  assign push      = accept && !is_ext && !is_rel;
  assign push_data = DEC ? {rel_f, ext_f, shreg} : {2'b00, shreg};
  assign tmo_hit   = (state != IDLE) && !fall &&
                     (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      bitcnt  <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
      tmo_cnt <= '0;
      ext_f   <= 1'b0;
      rel_f   <= 1'b0;
    end else begin
      if (state == IDLE || fall || tmo_hit) tmo_cnt <= '0;
      else                                  tmo_cnt <= tmo_cnt + TW'(1);

      if (tmo_hit) begin
        state <= IDLE;
        ext_f <= 1'b0;
        rel_f <= 1'b0;
      end else if (fall) begin
        case (state)
          IDLE: if (!din) begin
            state  <= DATA;
            bitcnt <= '0;
          end
          DATA: begin
            shreg  <= {din, shreg[7:1]};
            bitcnt <= bitcnt + 3'd1;
            if (bitcnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par_bit <= din;
            state   <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (!par_ok || !stop_ok) begin
              ext_f <= 1'b0;
              rel_f <= 1'b0;
            end else if (is_ext) begin
              ext_f <= 1'b1;
            end else if (is_rel) begin
              rel_f <= 1'b1;
            end else begin
              ext_f <= 1'b0;
              rel_f <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // When full, rd_en is always a real pop, so push+pop never drops.
  assign ovf_set = push && full && !rd_en;

  // Set beats clear so an error coincident with err_clr is not lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      overflow   <= ovf_set | (overflow & ~err_clr);
      parity_err <= (stop_edge && !par_ok) | (parity_err & ~err_clr);
      frame_err  <= (stop_edge && !stop_ok) | tmo_hit | (frame_err & ~err_clr);
    end
  end

  sync_fifo #(.WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (rd_en),
    .rd_data   (rd_data),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  assign rd_valid = !empty;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
module tb_ps2_rx_fifo;
  localparam int FD   = 8;
  localparam int SS   = 2;
  localparam int TO   = 100;
  localparam int HALF = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ps2_clk = 1'b1, ps2_data = 1'b1;
  logic rd_en = 1'b0, rd_en_r = 1'b0, err_clr = 1'b0;

  logic [9:0] rd_data, rd_data_r;
  logic       rd_valid, rd_valid_r;
  logic [3:0] count, count_r;
  logic       ovf, perr, ferr, ovf_r, perr_r, ferr_r;

  ps2_rx_fifo #(.FIFO_DEPTH(FD), .SYNC_STAGES(SS), .TIMEOUT_CYCLES(TO), .DECODE_PREFIX(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .count(count),
    .overflow(ovf), .parity_err(perr), .frame_err(ferr), .err_clr(err_clr));

  ps2_rx_fifo #(.FIFO_DEPTH(FD), .SYNC_STAGES(SS), .TIMEOUT_CYCLES(TO), .DECODE_PREFIX(0)) u_raw (
    .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .rd_en(rd_en_r), .rd_data(rd_data_r), .rd_valid(rd_valid_r), .count(count_r),
    .overflow(ovf_r), .parity_err(perr_r), .frame_err(ferr_r), .err_clr(err_clr));

  always #5 clk = ~clk;

  // Frame-level model: queues of expected entries plus expected flags.
  logic [9:0] q_m[$], q_r[$];
  bit e_ovf_m, e_ovf_r, e_perr, e_ferr, m_ext, m_rel;
  bit chk_en = 1'b0;
  int n_checks = 0, n_pass = 0;

  task automatic check(input string nm, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
  endtask

  always @(negedge clk) if (chk_en) begin
    check("valid", int'(rd_valid), int'(q_m.size() != 0));
    check("count", int'(count), q_m.size());
    if (q_m.size() != 0) check("data", int'(rd_data), int'(q_m[0]));
    check("ovf", int'(ovf), int'(e_ovf_m));
    check("perr", int'(perr), int'(e_perr));
    check("ferr", int'(ferr), int'(e_ferr));
    check("raw_valid", int'(rd_valid_r), int'(q_r.size() != 0));
    check("raw_count", int'(count_r), q_r.size());
    if (q_r.size() != 0) check("raw_data", int'(rd_data_r), int'(q_r[0]));
    check("raw_ovf", int'(ovf_r), int'(e_ovf_r));
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_m(input logic [9:0] e);
    if (q_m.size() >= FD) e_ovf_m = 1'b1; else q_m.push_back(e);
  endtask

  task automatic push_r(input logic [9:0] e);
    if (q_r.size() >= FD) e_ovf_r = 1'b1; else q_r.push_back(e);
  endtask

  task automatic model_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop, input bit pop_m);
    if (bad_par)  e_perr = 1'b1;
    if (bad_stop) e_ferr = 1'b1;
    if (bad_par || bad_stop) begin
      m_ext = 1'b0; m_rel = 1'b0;
    end else begin
      if (pop_m && q_m.size() != 0) void'(q_m.pop_front());
      if (b == 8'hE0) m_ext = 1'b1;
      else if (b == 8'hF0) m_rel = 1'b1;
      else begin
        push_m({m_rel, m_ext, b});
        m_ext = 1'b0; m_rel = 1'b0;
      end
      push_r({2'b00, b});
    end
  endtask

  // pop_stop raises rd_en on exactly the stop-sample cycle (SS sync flops
  // plus the edge-detect flop after the pin falls).
  task automatic send_frame(input logic [7:0] b, input bit bad_par = 0,
                            input bit bad_stop = 0, input bit pop_stop = 0);
    logic [10:0] frm;
    frm = {~bad_stop, (bad_par ? ^b : ~^b), b, 1'b0};
    chk_en = 1'b0;
    for (int i = 0; i < 11; i++) begin
      ps2_data = frm[i];
      cyc(HALF);
      ps2_clk = 1'b0;
      if (i == 10 && pop_stop) begin
        cyc(SS);
        rd_en = 1'b1;
        cyc(1);
        rd_en = 1'b0;
        cyc(HALF - SS - 1);
      end else cyc(HALF);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    cyc(HALF);
    model_frame(b, bad_par, bad_stop, pop_stop);
    chk_en = 1'b1;
  endtask

  task automatic send_partial(input logic [7:0] b, input int nbits);
    chk_en = 1'b0;
    for (int i = 0; i <= nbits; i++) begin
      ps2_data = (i == 0) ? 1'b0 : b[i-1];
      cyc(HALF);
      ps2_clk = 1'b0;
      cyc(HALF);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  task automatic pop(input bit m, input bit r);
    rd_en = m; rd_en_r = r;
    cyc(1);
    rd_en = 1'b0; rd_en_r = 1'b0;
    if (m && q_m.size() != 0) void'(q_m.pop_front());
    if (r && q_r.size() != 0) void'(q_r.pop_front());
  endtask

  task automatic clr();
    err_clr = 1'b1;
    cyc(1);
    err_clr = 1'b0;
    e_ovf_m = 0; e_ovf_r = 0; e_perr = 0; e_ferr = 0;
  endtask

  task automatic model_reset();
    q_m.delete(); q_r.delete();
    e_ovf_m = 0; e_ovf_r = 0; e_perr = 0; e_ferr = 0; m_ext = 0; m_rel = 0;
  endtask

  task automatic check_reset_state();
    @(negedge clk);
    check("rst_valid", int'(rd_valid), 0);
    check("rst_count", int'(count), 0);
    check("rst_data", int'(rd_data), 0);
    check("rst_flags", int'({ovf, perr, ferr}), 0);
    check("rst_raw", int'({rd_valid_r, count_r, rd_data_r}), 0);
  endtask

  initial begin
    model_reset();
    cyc(5);
    rst_n = 1'b1;
    check_reset_state();
    chk_en = 1'b1;

    // plain make code
    send_frame(8'h1C);
    @(negedge clk);
    check("lit_1c", int'(rd_data), 10'h01C);
    check("lit_1c_cnt", int'(count), 1);
    pop(1, 1);
    @(negedge clk);
    check("lit_pop_empty", int'(rd_valid), 0);

    // extended make, then extended break
    send_frame(8'hE0);
    send_frame(8'h75);
    @(negedge clk);
    check("lit_175", int'(rd_data), 10'h175);
    check("lit_raw_e0", int'(rd_data_r), 10'h0E0);
    pop(1, 1);
    @(negedge clk);
    check("lit_raw_75", int'(rd_data_r), 10'h075);
    pop(0, 1);
    send_frame(8'hE0);
    send_frame(8'hF0);
    send_frame(8'h75);
    @(negedge clk);
    check("lit_375", int'(rd_data), 10'h375);
    check("lit_375_cnt", int'(count), 1);
    check("lit_raw_cnt3", int'(count_r), 3);
    pop(1, 1);
    @(negedge clk);
    check("lit_raw_f0", int'(rd_data_r), 10'h0F0);
    pop(0, 1);
    pop(0, 1);

    // bad parity, clear, recover
    send_frame(8'h1C, 1);
    @(negedge clk);
    check("lit_perr", int'(perr), 1);
    check("lit_perr_cnt", int'(count), 0);
    clr();
    @(negedge clk);
    check("lit_perr_clr", int'(perr), 0);
    send_frame(8'h1C);
    @(negedge clk);
    check("lit_1c_again", int'(rd_data), 10'h01C);
    pop(1, 1);

    // truncated frame times out
    send_partial(8'hA5, 4);
    cyc(TO + 50);
    e_ferr = 1'b1; m_ext = 0; m_rel = 0;
    chk_en = 1'b1;
    @(negedge clk);
    check("lit_tmo_ferr", int'(ferr), 1);
    check("lit_tmo_cnt", int'(count), 0);
    send_frame(8'h29);
    @(negedge clk);
    check("lit_029", int'(rd_data), 10'h029);
    pop(1, 1);
    clr();

    // overflow
    for (int i = 1; i <= 9; i++) send_frame(8'(i));
    @(negedge clk);
    check("lit_full_cnt", int'(count), 8);
    check("lit_ovf", int'(ovf), 1);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      check("lit_pop_seq", int'(rd_data), i);
      pop(1, 1);
    end
    for (int i = 8'h11; i <= 8'h18; i++) send_frame(8'(i));
    clr();
    send_frame(8'h19, 0, 0, 1);
    @(negedge clk);
    check("lit_pp_ovf", int'(ovf), 0);
    check("lit_pp_cnt", int'(count), 8);
    check("lit_pp_head", int'(rd_data), 10'h012);
    for (int i = 0; i < 8; i++) pop(1, 1);
    @(negedge clk);
    check("lit_drained", int'(rd_valid), 0);
    clr();

    // reset mid-frame
    send_frame(8'hE0);
    send_partial(8'h33, 3);
    chk_en = 1'b0;
    rst_n = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    model_reset();
    check_reset_state();
    chk_en = 1'b1;
    send_frame(8'h5A);
    @(negedge clk);
    check("lit_05a", int'(rd_data), 10'h05A);
    pop(1, 1);
    cyc(5);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ps2_rx_fifo.md
Name: ps2_rx_fifo

Overview:
Synthesizable PS/2 host receiver. It samples the keyboard's open-collector clock/data lines, checks start, odd-parity and stop bits, and merges E0/F0 prefixes into one tagged entry. Entries are buffered in a parametrised FIFO for the CPU-side keyboard peripheral. It sits between the ps2_clk/ps2_data pins and the memory-mapped keyboard register block on sys_clk. It generalises the fixed single-byte receive path with depth, synchroniser length, prefix decoding, timeout recovery and sticky error reporting.

Parameters:
FIFO_DEPTH, 8, entry count; power of two, >=2
SYNC_STAGES, 2, synchroniser flops on each PS/2 input; >=2
TIMEOUT_CYCLES, 20000, clk cycles with no PS/2 falling edge before an in-progress frame is aborted
DECODE_PREFIX, 1, 1 = merge E0/F0 into flags; 0 = push every byte raw with flags 0

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
ps2_clk  in  1  PS/2 clock pin, asynchronous
ps2_data  in  1  PS/2 data pin, asynchronous
rd_en  in  1  pop head entry
rd_data  out  10  head entry {release, extended, code[7:0]}, show-ahead
rd_valid  out  1  FIFO not empty
count  out  $clog2(FIFO_DEPTH)+1  entries held
overflow  out  1  sticky: entry dropped because FIFO full
parity_err  out  1  sticky: frame had bad parity
frame_err  out  1  sticky: bad stop bit or timeout
err_clr  in  1  clear all sticky flags

Behaviour:
- Reset (async, rst_n=0): FSM IDLE, FIFO empty, prefix flags 0, timeout counter 0; rd_valid=0, count=0, rd_data=0, all error flags 0. Reset mid-frame discards the partial frame.
- Both pins pass through SYNC_STAGES flops. A falling edge means previous synced ps2_clk=1 and current=0. All sampling happens only on that cycle.
- FSM:
  - IDLE: on edge with data=0 -> DATA, bitcnt=0. On edge with data=1, stay IDLE (glitch, no error).
  - DATA: shift data in LSB first. After 8th bit -> PARITY.
  - PARITY: store bit -> STOP.
  - STOP: on edge -> IDLE.
    - data=1 and ^{byte,parity}=1: byte accepted.
    - Parity wrong: parity_err=1, byte discarded.
    - Stop=0: frame_err=1, byte discarded.
    - Both wrong: both flags set.
- Timeout: outside IDLE, counter increments each cycle and is reset by every falling edge. When it reaches TIMEOUT_CYCLES: -> IDLE, frame_err=1, prefix flags cleared.
- Prefix decode (DECODE_PREFIX=1), on accepted byte:
  - 0xE0 sets ext; 0xF0 sets rel; neither is pushed.
  - Any other byte pushes {rel,ext,byte}, then clears both flags.
  - Repeated prefixes are idempotent.
  - Any parity or frame error clears both flags.
  - DECODE_PREFIX=0: every accepted byte is pushed as {0,0,byte}.
- Latency: the push is written at the clk edge ending the STOP-sample cycle; rd_valid=1 the next cycle.
- FIFO:
  - rd_data always shows the head.
  - rd_en with rd_valid=0 is ignored.
  - Pointers are $clog2(FIFO_DEPTH)+1 bits and wrap naturally.
  - Push when full without a pop: entry dropped, overflow=1, contents unchanged.
  - Push and pop in the same cycle when full: both occur, no overflow, count unchanged.
  - Push and pop in the same cycle when empty: push occurs, pop ignored.
- Sticky flags: err_clr clears them. A new error in the same cycle as err_clr wins, so the flag stays 1.

Decomposition:
- Shared package ps2_pkg:
  - FSM state enum: IDLE, DATA, PARITY, STOP.
  - Constants PS2_PREFIX_EXT=8'hE0 and PS2_PREFIX_REL=8'hF0.
  - Entry field indices: CODE 7:0, EXT 8, REL 9.
- Sub-module sync_fifo #(WIDTH, DEPTH): storage, pointers, count, full/empty. The same-cycle rules above are its contract; it is reusable for the UART RX path.

Test Plan:
- Frame 0x1C (parity 0, stop 1) -> rd_data=10'h01C, rd_valid=1 one cycle after stop sample, count=1; rd_en -> rd_valid=0.
- Frames E0,75 -> single entry 10'h175. Frames E0,F0,75 -> 10'h375. With DECODE_PREFIX=0, the same frames give 10'h0E0, 10'h0F0, 10'h075.
- Frame 0x1C with parity bit 1 -> parity_err=1, count=0. Then err_clr -> 0. Then a good 0x1C -> 10'h01C.
- Start plus 4 data bits, then idle > TIMEOUT_CYCLES -> frame_err=1, FSM IDLE. Then a good frame 0x29 -> 10'h029.
- 9 frames 0x01..0x09 with no reads (depth 8) -> count=8, overflow=1, pops return 0x01..0x08. Pop coincident with a 10th push when full -> no overflow change, count stays 8.
- rst_n low mid-frame after 3 bits, then released -> all outputs 0. The next full frame 0x5A is received correctly as 10'h05A.
